data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter XLEN, 32, data/address width in bits.
REQ-002 Parameter MEM_WORDS, 1024, memory depth in 32-bit words; power of two.
REQ-003 Parameter LATENCY, 2, cycles from request accept to response valid; legal range 1..15.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset; synchronous, active-high.
REQ-006 req_valid_i  input  1  core presents a memory request.
REQ-007 req_ready_o  output  1  block can accept a request.
REQ-008 req_addr_i  input  XLEN  byte address.
REQ-009 req_we_i  input  1  1 = store, 0 = load.
REQ-010 req_funct3_i  input  3  RV32I access size. Loads: LB=0, LH=1, LW=2, LBU=4, LHU=5. Stores: SB=0, SH=1, SW=2.
REQ-011 req_wdata_i  input  XLEN  store data, right-aligned.
REQ-012 rsp_valid_o  output  1  response available.
REQ-013 rsp_ready_i  input  1  core consumes the response.
REQ-014 rsp_rdata_o  output  XLEN  load result, already extended; 0 for stores and errors.
REQ-015 rsp_err_o  output  1  request was misaligned, out of range, or had an illegal funct3.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-017 The block SHALL drive req_ready_o=1 only in IDLE and rsp_valid_o=1 only in RESP.
REQ-018 On req_valid_i & req_ready_o, the block SHALL capture addr, we, funct3 and wdata into registers; later input changes SHALL have no effect on the request.
REQ-019 On accept, the block SHALL go to RESP if LATENCY=1; otherwise it SHALL go to WAIT with the counter loaded with LATENCY-2.
REQ-020 In WAIT, the counter SHALL decrement every cycle; when the counter is 0, the block SHALL go to RESP at the next edge.
REQ-021 rsp_valid_o SHALL first be high exactly LATENCY cycles after the accept edge.
REQ-022 The memory access (read sample or write commit) SHALL occur on the edge that enters RESP; the response registers SHALL be loaded on the same edge.
REQ-023 In RESP, rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL stay stable while rsp_ready_i=0.
REQ-024 On rsp_valid_o & rsp_ready_i, the block SHALL return to IDLE. A new request SHALL NOT be accepted in the same cycle, so minimum spacing between accepts is LATENCY+1 cycles.
REQ-025 Word index SHALL be addr[log2(MEM_WORDS)+1:2]. A request is out of range when addr >= 4*MEM_WORDS.
REQ-026 A request is misaligned when it is a halfword access with addr[0]=1, or a word access with addr[1:0]≠0.
REQ-027 Illegal funct3 SHALL be 3, 6 or 7 for loads, and 3..7 for stores.
REQ-028 An erroring request SHALL set rsp_err_o=1 and rsp_rdata_o=0, and SHALL leave memory unchanged.
REQ-029 Load extraction: LB/LBU SHALL select byte addr[1:0]; LH/LHU SHALL select halfword addr[1]; LW SHALL return the whole word.
REQ-030 LB and LH results SHALL be sign-extended; LBU and LHU results SHALL be zero-extended.
REQ-031 SB SHALL write wdata[7:0] to byte lane addr[1:0]; SH SHALL write wdata[15:0] to halfword lane addr[1]; SW SHALL write the whole word. Unselected bytes SHALL be preserved.
REQ-032 A store response SHALL carry rsp_rdata_o=0, with rsp_err_o per REQ-028.
REQ-033 While not in IDLE, req_valid_i SHALL be ignored.

Reset
REQ-034 While rst_i=1 at an edge, the block SHALL enter IDLE and clear the counter. Outputs SHALL take these values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
REQ-035 Memory contents SHALL NOT be reset.
REQ-036 Reset in WAIT SHALL discard the pending request, including an uncommitted store.
REQ-037 A store committed before reset SHALL persist after reset.
REQ-038 A request presented in the same cycle as rst_i=1 SHALL NOT be accepted.

Verification (LATENCY=2, MEM_WORDS=1024)
REQ-039 SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata_o=0xDEADBEEF, rsp_err_o=0, rsp_valid_o high 2 cycles after each accept.
REQ-040 After REQ-039, SB 0x80 @0x11; then LB @0x11 -> 0xFFFFFF80, LBU @0x11 -> 0x00000080, LW @0x10 -> 0xDEAD80EF.
REQ-041 LH @0x13 -> rsp_err_o=1, rsp_rdata_o=0; SW @0x12 -> rsp_err_o=1, and a following LW @0x10 is unchanged; LW @0x1000 -> rsp_err_o=1.
REQ-042 Hold rsp_ready_i=0 for 5 cycles in RESP with req_valid_i=1 -> rsp_valid_o, rsp_rdata_o and rsp_err_o stable; req_ready_o=0; no new accept.
REQ-043 SW 0x12345678 @0x20 with rst_i pulsed during WAIT -> outputs reach their reset values on the next edge; a following LW @0x20 returns the pre-store value.
REQ-044 Back-to-back requests with rsp_ready_i tied high -> accepts spaced exactly 3 cycles apart.

Source files
------------

// File: rtl/data_mem_responder.sv
// Single-port data memory responder for an RV32I-style core: accepts one request,
// waits LATENCY cycles, then performs the access and holds the response until consumed.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; req_ready_o high
// WAIT  | request captured; down-counter running toward terminal count
// RESP  | access done; response held until rsp_ready_i
module data_mem_responder #(
    parameter int XLEN      = 32,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic            req_we_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = 4;
    localparam int unsigned CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [31:0]       mem [MEM_WORDS];

    logic              enter_resp;
    logic [XLEN-1:0]   acc_addr;
    logic [XLEN-1:0]   acc_wdata;
    logic              acc_we;
    logic [2:0]        acc_f3;
    logic              out_of_range;
    logic              misaligned;
    logic              illegal_f3;
    logic              acc_err;
    logic [AW-1:0]     word_idx;
    logic [31:0]       rd_word;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [XLEN-1:0]   load_val;
    logic [3:0]        st_be;
    logic [31:0]       st_lane;
    logic              mem_we;

    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    // With LATENCY=1 the access happens on the accept edge, so it must use the live inputs.
    always_comb begin
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_we    = we_q;
        acc_f3    = f3_q;
        if (state_q == ST_IDLE) begin
            acc_addr  = req_addr_i;
            acc_wdata = req_wdata_i;
            acc_we    = req_we_i;
            acc_f3    = req_funct3_i;
        end
    end

    always_comb begin
        out_of_range = |acc_addr[XLEN-1:AW+2];
        misaligned   = ((acc_f3[1:0] == 2'd1) && acc_addr[0]) ||
                       ((acc_f3[1:0] == 2'd2) && (acc_addr[1:0] != 2'd0));
        if (acc_we) begin
            illegal_f3 = (acc_f3 > 3'd2);
        end else begin
            illegal_f3 = (acc_f3 == 3'd3) || (acc_f3 >= 3'd6);
        end
        acc_err  = out_of_range | misaligned | illegal_f3;
        word_idx = acc_addr[AW+1:2];
    end

    assign rd_word  = mem[word_idx];
    assign byte_sel = rd_word[{acc_addr[1:0], 3'b000} +: 8];
    assign half_sel = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = '0;
        case (acc_f3)
            3'd0:    load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'd1:    load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'd2:    load_val = XLEN'(rd_word);
            3'd4:    load_val = {{(XLEN-8){1'b0}}, byte_sel};
            3'd5:    load_val = {{(XLEN-16){1'b0}}, half_sel};
            default: load_val = '0;
        endcase
    end

    always_comb begin
        st_be   = 4'b0000;
        st_lane = acc_wdata[31:0];
        case (acc_f3)
            3'd0: begin
                st_be   = 4'b0001 << acc_addr[1:0];
                st_lane = {4{acc_wdata[7:0]}};
            end
            3'd1: begin
                st_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
                st_lane = {2{acc_wdata[15:0]}};
            end
            3'd2: begin
                st_be   = 4'b1111;
                st_lane = acc_wdata[31:0];
            end
            default: begin
                st_be   = 4'b0000;
                st_lane = acc_wdata[31:0];
            end
        endcase
    end

    // Reset wins over a commit due on the same edge, so a store pending in WAIT is dropped.
    assign mem_we = enter_resp & acc_we & ~acc_err & ~rst_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        f3_d        = f3_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        enter_resp  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    we_d    = req_we_i;
                    f3_d    = req_funct3_i;
                    if (LATENCY == 1) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CW'(CNT_INIT);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_resp) begin
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err | acc_we) ? '0 : load_val;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Memory array has no reset; contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) begin
                    mem[word_idx][8*b +: 8] <= st_lane[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (LATENCY=2, MEM_WORDS=1024) with hand-computed
// expected responses, latencies and accept spacing.
module tb_data_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    data_mem_responder #(.XLEN(32), .MEM_WORDS(1024), .LATENCY(2)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full request/response; inputs are scrambled right after accept to show capture.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
        int n;
        rd  = '0;
        er  = 1'b0;
        lat = 0;
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wd;
        rsp_ready_i  = 1'b1;
        n = 0;
        while (!req_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) begin
            check_eq("accept_tmo", {31'd0, req_ready_o}, 32'd1);
            req_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i  = 1'b0;
        req_addr_i   = 32'hFFFF_FFFC;
        req_wdata_i  = 32'h5A5A_5A5A;
        req_we_i     = ~we;
        req_funct3_i = 3'd7;
        lat = 1;
        while (!rsp_valid_o && lat < 20) begin
            @(negedge clk_i);
            lat++;
        end
        if (!rsp_valid_o) begin
            check_eq("rsp_tmo", {31'd0, rsp_valid_o}, 32'd1);
            return;
        end
        rd = rsp_rdata_o;
        er = rsp_err_o;
        @(posedge clk_i);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        int          acc[$];

        rst_i        = 1'b1;
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_funct3_i = 3'd2;
        req_addr_i   = 32'h10;
        req_wdata_i  = 32'h0BAD_0BAD;
        rsp_ready_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq("rst_ready", {31'd0, req_ready_o}, 32'd1);
        check_eq("rst_valid", {31'd0, rsp_valid_o}, 32'd0);
        check_eq("rst_rdata", rsp_rdata_o, 32'd0);
        check_eq("rst_err",   {31'd0, rsp_err_o}, 32'd0);
        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        check_eq("post_rst_idle", {31'd0, req_ready_o}, 32'd1);

        xact(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
        check_eq("sw_err", {31'd0, er}, 32'd0);
        check_eq("sw_rdata", rd, 32'd0);
        check_eq("sw_lat", lat, 32'd2);
        xact(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        check_eq("lw_data", rd, 32'hDEAD_BEEF);
        check_eq("lw_err", {31'd0, er}, 32'd0);
        check_eq("lw_lat", lat, 32'd2);

        xact(1'b1, 3'd0, 32'h11, 32'h1234_5680, rd, er, lat);
        check_eq("sb_err", {31'd0, er}, 32'd0);
        xact(1'b0, 3'd0, 32'h11, 32'h0, rd, er, lat);
        check_eq("lb_data", rd, 32'hFFFF_FF80);
        xact(1'b0, 3'd4, 32'h11, 32'h0, rd, er, lat);
        check_eq("lbu_data", rd, 32'h0000_0080);
        xact(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        check_eq("lw_after_sb", rd, 32'hDEAD_80EF);
        xact(1'b0, 3'd1, 32'h12, 32'h0, rd, er, lat);
        check_eq("lh_data", rd, 32'hFFFF_DEAD);
        xact(1'b0, 3'd5, 32'h10, 32'h0, rd, er, lat);
        check_eq("lhu_data", rd, 32'h0000_80EF);

        xact(1'b0, 3'd1, 32'h13, 32'h0, rd, er, lat);
        check_eq("lh_mis_err", {31'd0, er}, 32'd1);
        check_eq("lh_mis_rdata", rd, 32'd0);
        xact(1'b1, 3'd2, 32'h12, 32'h1111_1111, rd, er, lat);
        check_eq("sw_mis_err", {31'd0, er}, 32'd1);
        xact(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        check_eq("lw_unchanged", rd, 32'hDEAD_80EF);
        xact(1'b0, 3'd2, 32'h1000, 32'h0, rd, er, lat);
        check_eq("lw_oor_err", {31'd0, er}, 32'd1);
        check_eq("lw_oor_rdata", rd, 32'd0);
        xact(1'b0, 3'd3, 32'h10, 32'h0, rd, er, lat);
        check_eq("ld_f3_ill", {31'd0, er}, 32'd1);
        xact(1'b1, 3'd4, 32'h10, 32'h2222_2222, rd, er, lat);
        check_eq("st_f3_ill", {31'd0, er}, 32'd1);
        xact(1'b1, 3'd2, 32'hFFC, 32'hA5A5_0001, rd, er, lat);
        xact(1'b0, 3'd2, 32'hFFC, 32'h0, rd, er, lat);
        check_eq("lw_top_word", rd, 32'hA5A5_0001);
        check_eq("lw_top_err", {31'd0, er}, 32'd0);
        xact(1'b1, 3'd1, 32'h12, 32'h7777_BEEF, rd, er, lat);
        xact(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        check_eq("lw_after_sh", rd, 32'hBEEF_80EF);

        // Response held off while the core keeps requesting.
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_funct3_i = 3'd2;
        req_addr_i   = 32'h10;
        rsp_ready_i  = 1'b0;
        n = 0;
        while (!rsp_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("hold_valid0", {31'd0, rsp_valid_o}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check_eq("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
            check_eq("hold_rdata", rsp_rdata_o, 32'hBEEF_80EF);
            check_eq("hold_err", {31'd0, rsp_err_o}, 32'd0);
            check_eq("hold_ready", {31'd0, req_ready_o}, 32'd0);
        end
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check_eq("hold_release", {31'd0, req_ready_o}, 32'd1);

        // Reset during WAIT drops an uncommitted store.
        xact(1'b1, 3'd2, 32'h20, 32'hCAFE_F00D, rd, er, lat);
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_funct3_i = 3'd2;
        req_addr_i   = 32'h20;
        req_wdata_i  = 32'h1234_5678;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check_eq("wait_ready", {31'd0, req_ready_o}, 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check_eq("wrst_ready", {31'd0, req_ready_o}, 32'd1);
        check_eq("wrst_valid", {31'd0, rsp_valid_o}, 32'd0);
        check_eq("wrst_rdata", rsp_rdata_o, 32'd0);
        check_eq("wrst_err", {31'd0, rsp_err_o}, 32'd0);
        rst_i = 1'b0;
        xact(1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat);
        check_eq("lw_prestore", rd, 32'hCAFE_F00D);
        xact(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        check_eq("lw_persist", rd, 32'hBEEF_80EF);

        // Back-to-back requests with the response always consumed.
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_funct3_i = 3'd2;
        req_addr_i   = 32'h10;
        rsp_ready_i  = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (req_ready_o) acc.push_back(c);
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        check_eq("b2b_count", {31'd0, acc.size() >= 4}, 32'd1);
        if (acc.size() >= 4) begin
            for (int i = 1; i < 4; i++) begin
                check_eq("b2b_gap", acc[i] - acc[i-1], 32'd3);
            end
        end
        n = 0;
        while (!req_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("final_idle", {31'd0, req_ready_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
